fir_coeff_ctrl: RTL
===================

# fir_coeff_ctrl

Coefficient controller for the 16-tap transposed FIR filter. It receives a new coefficient set serially over a valid/ready port into a shadow bank. Once all taps have arrived, it commits the whole set atomically to the active bank, which drives the filter's coefficient inputs. It also reports when the filter's delay line holds only post-reset samples, so downstream logic can qualify `o_signal`.

## Interface

Parameters:
- `CWIDTH`, default 16: coefficient width. It must match the filter's `WIDTH`.
- `TAPS`, default 16: number of coefficients, b0..b(TAPS-1).
- `CNTW`, default 5: counter width. It must satisfy 2^CNTW > TAPS.

Ports:
- `clk`  in  1: the single clock; all logic is rising-edge.
- `rst_n`  in  1: synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `i_cfg_start`  in  1: request a new load sequence. Sampled only in IDLE.
- `i_cfg_abort`  in  1: cancel the load in progress; the active bank is kept.
- `i_cfg_valid`  in  1: coefficient beat valid.
- `i_cfg_data`  in  CWIDTH: coefficient value. Beat k carries b_k (b0 first).
- `o_cfg_ready`  out  1: the block accepts a beat this cycle.
- `o_busy`  out  1: the FSM is in LOAD or COMMIT.
- `o_coeff`  out  TAPS*CWIDTH: active bank. b_k sits at bits [k*CWIDTH +: CWIDTH].
- `o_coeff_swap`  out  1: one-cycle pulse in the first cycle the new bank is visible.
- `o_fir_valid`  out  1: the filter delay line is fully populated since reset.

## Operation

- **FSM states:**
  - IDLE: `o_cfg_ready`=0, `o_busy`=0.
  - LOAD: `o_cfg_ready`=1, `o_busy`=1.
  - COMMIT: `o_cfg_ready`=0, `o_busy`=1.
- **Transitions:**
  - IDLE → LOAD on `i_cfg_start`=1 && `i_cfg_abort`=0. The beat counter clears to 0.
  - LOAD: on each handshake (`i_cfg_valid` && `o_cfg_ready`), shadow[cnt] <= `i_cfg_data` and cnt <= cnt+1.
  - LOAD → COMMIT on the handshake with cnt == TAPS-1.
  - LOAD → IDLE on `i_cfg_abort`=1. Shadow contents are don't-care; the active bank and `o_coeff_swap` are untouched.
  - COMMIT → IDLE unconditionally. On the COMMIT edge, active <= shadow and `o_coeff_swap` <= 1.
- **Gaps:** `i_cfg_valid` low during LOAD stalls the sequence indefinitely; there is no timeout.
- **`i_cfg_start` outside IDLE:** ignored, with no queuing.
- **`i_cfg_abort` outside LOAD:** ignored. In COMMIT it does not block the swap.
- **Abort and final beat in the same cycle:** abort wins. The beat is discarded and no commit occurs.
- **Start and abort in the same cycle in IDLE:** the FSM stays in IDLE.
- **Coefficient arithmetic:** coefficients are stored and passed unmodified, with no sign or width conversion.
- **`o_coeff` stability:** `o_coeff` changes only on the COMMIT edge or at reset. It never shows a partially loaded set.
- **Fill counter:** `fill` increments every cycle and saturates at TAPS. `o_fir_valid` = (fill == TAPS).
- **Reset values:**
  - FSM = IDLE, cnt = 0, fill = 0.
  - active bank b_k = k+1 (1..16 for TAPS=16). The shadow bank is also set to the same values.
  - `o_cfg_ready`=0, `o_busy`=0, `o_coeff_swap`=0, `o_fir_valid`=0.
- **Reset mid-load or in COMMIT:** the sequence is lost and the active bank returns to the defaults.

## Timing

- **Start:** `i_cfg_start` sampled high in IDLE at cycle t gives `o_cfg_ready`=1 and `o_busy`=1 from t+1.
- **Load throughput:** one beat per cycle. With back-to-back beats, the last beat is accepted at cycle t+TAPS.
- **Commit:** the last beat is accepted at cycle u.
  - Cycle u+1 is COMMIT: `o_cfg_ready`=0, `o_busy`=1.
  - Cycle u+2: the new `o_coeff` is visible, `o_coeff_swap`=1 for exactly this cycle, and `o_busy`=0.
- **Restart:** the earliest new start is sampled at u+2, giving start-to-start spacing of TAPS+2 cycles minimum.
- **Abort:** abort at cycle a in LOAD gives `o_cfg_ready`=0 and `o_busy`=0 at a+1.
- **All outputs are registered.**
  - Exceptions: `o_cfg_ready` and `o_busy` are decoded directly from the state register.
  - No output depends combinationally on any input.
- **`o_fir_valid`:** rises in the TAPS-th cycle after the cycle in which `rst_n` is deasserted (cycle 16 for TAPS=16). It then stays high until the next reset; coefficient swaps do not clear it.

## Test plan

- **Reset defaults:** hold `rst_n`=0 for 2 cycles, then release. Check `o_coeff` = {16,15,...,1} (b0=1 at the LSBs), all control outputs 0, and `o_fir_valid` rising exactly 16 cycles after release.
- **Back-to-back load:**
  - Stimulus: start, then 16 consecutive beats 0x0100..0x010F.
  - Check `o_cfg_ready` high for exactly 16 cycles, one COMMIT cycle, then `o_coeff_swap` for one cycle with b_k = 0x0100+k.
  - Check `o_coeff` unchanged before the swap.
- **Gapped load:** insert random `i_cfg_valid` low gaps (1–5 cycles) between beats. Check the same final bank as the back-to-back load and no swap before the 16th handshake.
- **Abort cases:**
  - Abort after 7 beats: no swap, `o_coeff` keeps its prior values, FSM back to IDLE next cycle.
  - Abort together with the 16th beat: no swap.
  - Start plus abort in IDLE: no load begins.
- **Ignored start:** pulse `i_cfg_start` during LOAD and during COMMIT. Check the beat count is not restarted and exactly one swap occurs.
- **Reset mid-load:** assert `rst_n`=0 after 10 beats. Check the active bank returns to 1..16, `o_fir_valid` drops to 0, and no swap pulse occurs.

Source files
------------

// File: rtl/fir_coeff_ctrl_if.sv
// rtl/fir_coeff_ctrl_if.sv - serial coefficient load port for fir_coeff_ctrl
interface fir_coeff_ctrl_if #(
  parameter int CWIDTH = 16
);
  logic              i_cfg_start;
  logic              i_cfg_abort;
  logic              i_cfg_valid;
  logic [CWIDTH-1:0] i_cfg_data;
  logic              o_cfg_ready;

  modport master (
    output i_cfg_start,
    output i_cfg_abort,
    output i_cfg_valid,
    output i_cfg_data,
    input  o_cfg_ready
  );

  modport slave (
    input  i_cfg_start,
    input  i_cfg_abort,
    input  i_cfg_valid,
    input  i_cfg_data,
    output o_cfg_ready
  );
endinterface

// File: rtl/fir_coeff_ctrl.sv
// rtl/fir_coeff_ctrl.sv - shadow/active coefficient banks with atomic commit for the transposed FIR
module fir_coeff_ctrl #(
  parameter int CWIDTH = 16,
  parameter int TAPS   = 16,
  parameter int CNTW   = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fir_coeff_ctrl_if.slave        cfg,
  output logic                   o_busy,
  output logic [TAPS*CWIDTH-1:0] o_coeff,
  output logic                   o_coeff_swap,
  output logic                   o_fir_valid
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNTW-1:0]   cnt;
  logic [CNTW-1:0]   fill;
  logic [CWIDTH-1:0] shadow [TAPS];
  logic [CWIDTH-1:0] active [TAPS];
  logic              start_ok;
  logic              hs;
  logic              last_beat;

  // Abort has priority over a beat, so an aborted final beat never reaches COMMIT.
  assign start_ok  = (state == IDLE) && cfg.i_cfg_start && !cfg.i_cfg_abort;
  assign hs        = (state == LOAD) && cfg.i_cfg_valid && !cfg.i_cfg_abort;
  assign last_beat = hs && (cnt == CNTW'(TAPS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cfg.o_cfg_ready = 1'b0;
    o_busy          = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        cfg.o_cfg_ready = 1'b1;
        o_busy          = 1'b1;
        if (cfg.i_cfg_abort) begin
          state_nxt = IDLE;
        end else if (last_beat) begin
          state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        o_busy    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      fill         <= '0;
      o_coeff_swap <= 1'b0;
      o_fir_valid  <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        shadow[k] <= CWIDTH'(k + 1);
        active[k] <= CWIDTH'(k + 1);
      end
    end else begin
      o_coeff_swap <= (state == COMMIT);
      if (state == COMMIT) begin
        for (int k = 0; k < TAPS; k++) begin
          active[k] <= shadow[k];
        end
      end
      if (start_ok) begin
        cnt <= '0;
      end else if (hs) begin
        cnt <= cnt + 1'b1;
        for (int k = 0; k < TAPS; k++) begin
          if (cnt == CNTW'(k)) begin
            shadow[k] <= cfg.i_cfg_data;
          end
        end
      end
      // Registered flag goes high on the same edge that brings fill to TAPS.
      if (fill != CNTW'(TAPS)) begin
        fill <= fill + 1'b1;
      end
      o_fir_valid <= (fill >= CNTW'(TAPS - 1));
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_pack
    assign o_coeff[k*CWIDTH +: CWIDTH] = active[k];
  end

endmodule
